// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, branch-flush bubbles
// and wrapping stall/flush event counters.
module id_ex_stage #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [XLEN-1:0]  id_pc,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       id_rd,
  input  logic [XLEN-1:0]  id_rdata1,
  input  logic [XLEN-1:0]  id_rdata2,
  input  logic [XLEN-1:0]  id_imm,
  input  logic [8:0]       id_ctrl,
  input  logic             ex_flush,
  output logic             stall,
  output logic             ex_valid,
  output logic [XLEN-1:0]  ex_pc,
  output logic [XLEN-1:0]  ex_rdata1,
  output logic [XLEN-1:0]  ex_rdata2,
  output logic [XLEN-1:0]  ex_imm,
  output logic [4:0]       ex_rs1,
  output logic [4:0]       ex_rs2,
  output logic [4:0]       ex_rd,
  output logic [8:0]       ex_ctrl,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  // ctrl layout: {reg_write,mem_read,mem_write,mem_to_reg,branch,alu_src,alu_op[1:0],jump}
  localparam int CTRL_MEM_READ = 7;

  // Counters wrap modulo 2^CNT_W; no saturation.
  function automatic logic [CNT_W-1:0] wrap_inc(input logic [CNT_W-1:0] v);
    return v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  logic             vld_p0;
  logic [8:0]       ctrl_p0;
  logic [XLEN-1:0]  pc_p0;
  logic [XLEN-1:0]  rdata1_p0;
  logic [XLEN-1:0]  rdata2_p0;
  logic [XLEN-1:0]  imm_p0;
  logic [4:0]       rs1_p0;
  logic [4:0]       rs2_p0;
  logic [4:0]       rd_p0;
  logic [CNT_W-1:0] stall_cnt_p0;
  logic [CNT_W-1:0] flush_cnt_p0;

  logic hazard;
  logic rd_match;

  always_comb begin
    rd_match = (rd_p0 != 5'd0) && ((rd_p0 == id_rs1) || (rd_p0 == id_rs2));
    hazard   = id_valid && vld_p0 && ctrl_p0[CTRL_MEM_READ] && rd_match;
    stall    = hazard && !ex_flush && !reset;
  end

  // ---- ID -> EX boundary: control, valid and event counters ----
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p0       <= 1'b0;
      ctrl_p0      <= '0;
      stall_cnt_p0 <= '0;
      flush_cnt_p0 <= '0;
    end else if (ex_flush) begin
      vld_p0       <= 1'b0;
      ctrl_p0      <= '0;
      flush_cnt_p0 <= wrap_inc(flush_cnt_p0);
    end else if (hazard) begin
      // The decode instruction is held in IF/ID by stall and re-presented next cycle.
      vld_p0       <= 1'b0;
      ctrl_p0      <= '0;
      stall_cnt_p0 <= wrap_inc(stall_cnt_p0);
    end else begin
      vld_p0       <= id_valid;
      ctrl_p0      <= id_valid ? id_ctrl : 9'd0;
    end
  end

  // Data fields follow the inputs whenever not in reset; in a bubble they are don't-care.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_p0     <= '0;
      rdata1_p0 <= '0;
      rdata2_p0 <= '0;
      imm_p0    <= '0;
      rs1_p0    <= '0;
      rs2_p0    <= '0;
      rd_p0     <= '0;
    end else begin
      pc_p0     <= id_pc;
      rdata1_p0 <= id_rdata1;
      rdata2_p0 <= id_rdata2;
      imm_p0    <= id_imm;
      rs1_p0    <= id_rs1;
      rs2_p0    <= id_rs2;
      rd_p0     <= id_rd;
    end
  end

  assign ex_valid    = vld_p0;
  assign ex_ctrl     = ctrl_p0;
  assign ex_pc       = pc_p0;
  assign ex_rdata1   = rdata1_p0;
  assign ex_rdata2   = rdata2_p0;
  assign ex_imm      = imm_p0;
  assign ex_rs1      = rs1_p0;
  assign ex_rs2      = rs2_p0;
  assign ex_rd       = rd_p0;
  assign stall_count = stall_cnt_p0;
  assign flush_count = flush_cnt_p0;

endmodule
